// File: rtl/grad_frame_streamer.sv
// -----------------------------------------------------------------------------
// grad_frame_streamer
//
// Purpose:
//   Reads a stored gradient/intensity frame from a synchronous-read BRAM in
//   raster order. It streams the frame as pixels into the 3x3 window line
//   buffers of the Canny pipeline. The fixed BRAM read latency is absorbed by
//   a 4-entry credit-controlled output FIFO, so downstream hold never loses a
//   pixel. After the last real pixel, FLUSH_PIXELS zero pixels are appended so
//   the window generator drains its final rows. frame_done is then pulsed.
//
// Optional feature (macro GRAD_STREAM_COORD_EN):
//   When defined, adds pix_x / pix_y coordinate outputs, registered alongside
//   pix_data. During flush, pix_y = DEPTH and pix_x is the flush index mod WIDTH.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   frame_start in   one-cycle request to stream a frame (ignored while busy)
//   hold        in   downstream stall; no pixel presented while high
//   rd_en       out  BRAM read enable
//   rd_addr     out  BRAM read address
//   rd_data     in   BRAM read data, valid RD_LATENCY cycles after rd_en
//   pix_valid   out  pixel strobe
//   pix_data    out  pixel value (zero during flush)
//   pix_last    out  high with the final flush pixel
//   busy        out  high from accepted frame_start until frame_done
//   frame_done  out  one-cycle pulse, the cycle after pix_last
//   pix_x/pix_y out  (GRAD_STREAM_COORD_EN only) pixel coordinates
// -----------------------------------------------------------------------------
module grad_frame_streamer #(
  parameter int WIDTH        = 512,
  parameter int DEPTH        = 638,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 19,
  parameter int RD_LATENCY   = 2,
  parameter int FLUSH_PIXELS = 514
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  frame_done
`ifdef GRAD_STREAM_COORD_EN
  ,
  output logic [9:0]            pix_x,
  output logic [9:0]            pix_y
`endif
);

  localparam int FCW_RAW = $clog2(FLUSH_PIXELS + 1);
  localparam int FCW     = (FCW_RAW > 10) ? FCW_RAW : 10;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WIDTH * DEPTH - 1);
  localparam logic [FCW-1:0]        FLUSH_LAST = FCW'((FLUSH_PIXELS == 0) ? 0 : FLUSH_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    issued_all_q;
  logic [RD_LATENCY-1:0]   tag_q;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [4];
  logic [1:0]              wr_ptr_q;
  logic [1:0]              rd_ptr_q;
  logic [2:0]              count_q;
  logic [FCW-1:0]          flush_cnt_q;
  logic                    pix_valid_q;
  logic [DATA_WIDTH-1:0]   pix_data_q;
  logic                    pix_last_q;
  logic                    busy_q;
  logic                    frame_done_q;

  logic [2:0]              inflight;
  logic                    credit_ok;
  logic                    rd_fire;
  logic                    wr_en;
  logic                    pop;
  logic                    drain;
  logic                    flush_emit;
  logic                    flush_last;
  logic [2:0]              count_d;
  logic [DATA_WIDTH-1:0]   fifo_head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {2'b00, tag_q[i]};
    end
  end

  // The oldest tag marks the cycle in which rd_data carries a requested word.
  assign wr_en     = tag_q[RD_LATENCY-1];
  assign credit_ok = ({1'b0, count_q} + {1'b0, inflight}) < 4'd4;
  assign rd_fire   = (state_q == S_READ) && !issued_all_q && credit_ok;

  // An empty FIFO passes returning data straight through, saving one cycle of
  // latency. Pointers still advance together, so the count stays unchanged.
  assign pop       = (state_q == S_READ) && !hold && ((count_q != 3'd0) || wr_en);
  assign fifo_head = (count_q != 3'd0) ? fifo_mem_q[rd_ptr_q] : rd_data;
  assign count_d   = count_q + {2'b00, wr_en} - {2'b00, pop};

  // The frame is drained once nothing will be left after this edge. Deciding
  // on next-state values avoids a bubble between the last pixel and the flush.
  assign drain      = issued_all_q && (count_d == 3'd0) && ((inflight - {2'b00, wr_en}) == 3'd0);
  assign flush_emit = (state_q == S_FLUSH) && !hold;
  assign flush_last = flush_emit && (flush_cnt_q == FLUSH_LAST);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem_q[wr_ptr_q] <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      issued_all_q <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flush_cnt_q  <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tag_q[0] <= rd_fire;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 2'd1;

      if (rd_fire) begin
        rd_addr_q <= rd_addr_q + 1'b1;
        if (rd_addr_q == LAST_ADDR) issued_all_q <= 1'b1;
      end

      pix_valid_q  <= pop || flush_emit;
      pix_data_q   <= pop ? fifo_head : '0;
      pix_last_q   <= flush_last || ((FLUSH_PIXELS == 0) && pop && drain);
      frame_done_q <= (state_q == S_DONE);

      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_q      <= S_READ;
            busy_q       <= 1'b1;
            rd_addr_q    <= '0;
            issued_all_q <= 1'b0;
            flush_cnt_q  <= '0;
          end
        end
        S_READ: begin
          if (drain) state_q <= (FLUSH_PIXELS == 0) ? S_DONE : S_FLUSH;
        end
        S_FLUSH: begin
          if (flush_emit) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
            if (flush_last) state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en      = rd_fire;
  assign rd_addr    = rd_addr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_last   = pix_last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef GRAD_STREAM_COORD_EN
  logic [9:0] x_cnt_q, y_cnt_q, pix_x_q, pix_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else if ((state_q == S_IDLE) && frame_start) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      if (pop || flush_emit) begin
        pix_x_q <= x_cnt_q;
        pix_y_q <= y_cnt_q;
      end
      // Entering flush restarts x and parks y on the virtual row DEPTH.
      if ((state_q == S_READ) && drain) begin
        x_cnt_q <= '0;
        y_cnt_q <= 10'(DEPTH);
      end else if (pop || flush_emit) begin
        if (x_cnt_q == 10'(WIDTH - 1)) begin
          x_cnt_q <= '0;
          if (state_q == S_READ) y_cnt_q <= y_cnt_q + 10'd1;
        end else begin
          x_cnt_q <= x_cnt_q + 10'd1;
        end
      end
    end
  end

  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
`endif

endmodule
